// File: rtl/uart_rx_fifo_if.sv
// Consumer-side read port of the UART receive FIFO.
// slave is the FIFO side; master is the byte consumer.
interface uart_rx_fifo_if;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;

    modport master (output rd_en, input rd_data, empty, full);
    modport slave  (input rd_en, output rd_data, empty, full);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// first-word-fall-through FIFO of 2^FIFO_DEPTH_LOG2 bytes.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT    = 434,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rx,
    uart_rx_fifo_if.slave  bus,
    output logic           busy,
    output logic           frame_err,
    output logic           overrun,
    output logic           parity_err
);
    localparam int CB    = $clog2(CLKS_PER_BIT);
    localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    localparam logic [CB-1:0]              BIT_LAST  = CB'(CLKS_PER_BIT - 1);
    localparam logic [CB-1:0]              HALF_LAST = CB'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CB-1:0]              CNT_ONE   = CB'(1);
    localparam logic [CNT_W-1:0]           OCC_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]           OCC_FULL  = CNT_W'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t      state;
    logic [CB-1:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        rx_meta;
    logic        rxs;
    logic        par_bad;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]           count;
    logic [CNT_W-1:0]           count_next;
    logic                       empty_q;
    logic                       full_q;
    logic                       push_req;
    logic                       push_ok;
    logic                       pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // A byte is offered on the stop-sample cycle itself so that IDLE is
    // re-entered in time to catch a back-to-back start bit.
    assign push_req = (state == STOP) && (cnt == BIT_LAST) && rxs && !par_bad;
    assign pop      = bus.rd_en && !empty_q;
    assign push_ok  = push_req && (!full_q || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            cnt   <= '0;
                            idx   <= '0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        par_bad    <= (rxs != ^shreg);
                        parity_err <= (rxs != ^shreg);
                        state      <= STOP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + OCC_ONE;
        end else if (!push_ok && pop) begin
            count_next = count - OCC_ONE;
        end
    end

    // Storage is deliberately left out of reset; rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count   <= count_next;
            empty_q <= (count_next == '0);
            full_q  <= (count_next == OCC_FULL);
            overrun <= push_req && full_q && !pop;
        end
    end

    assign bus.empty   = empty_q;
    assign bus.full    = full_q;
    assign bus.rd_data = empty_q ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised self-checking bench for uart_rx_fifo against a queue-based model.
// Honours UART_RX_PARITY_EN the same way the design does.
module tb_uart_rx_fifo;
    localparam int CLKS  = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS  = 10 + PAR;
    localparam int STOP_C = 2 + CLKS / 2 + CLKS * (9 + PAR);
    localparam int RST_C  = 4 * CLKS + 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    logic busy, frame_err, overrun, parity_err;

    uart_rx_fifo_if bus();

    uart_rx_fifo #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH_LOG2(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .bus        (bus),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int frameErrCnt = 0, overrunCnt = 0, parityErrCnt = 0, busyCycles = 0;
    int expFrameErr = 0, expOverrun = 0, expParity = 0;
    logic [7:0] modelQ[$];
    logic snapBefore, snapAfter;
    logic [7:0] snapData;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (frame_err)  frameErrCnt++;
        if (overrun)    overrunCnt++;
        if (parity_err) parityErrCnt++;
        if (busy)       busyCycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one frame on rx, one negedge per clock; optionally pops on the
    // stop-sample cycle or asserts reset from mid bit 3 to the end of the frame.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic badParity,
                                 input logic popAtStop, input logic resetMid);
        logic [10:0] frm;
        int k;
        frm = {stopBit, (^data) ^ badParity, data, 1'b0};
        for (int c = 0; c < NBITS * CLKS; c++) begin
            k = c / CLKS;
            if (PAR == 0 && k == 9) k = 10;
            rx = frm[k];
            bus.rd_en = popAtStop && (c == STOP_C);
            if (resetMid && c == RST_C) reset = 1'b1;
            if (c == STOP_C) snapBefore = bus.empty;
            if (c == STOP_C + 1) begin
                snapAfter = bus.empty;
                snapData  = bus.rd_data;
            end
            @(negedge clk);
        end
        bus.rd_en = 1'b0;
        if (resetMid) reset = 1'b0;
    endtask

    task automatic modelPush(input logic [7:0] data);
        if (modelQ.size() < DEPTH) modelQ.push_back(data);
        else expOverrun++;
    endtask

    task automatic popCheck();
        checkOutput("pop_empty", 32'(bus.empty), 32'(modelQ.size() == 0));
        if (modelQ.size() != 0) begin
            checkOutput("pop_data", 32'(bus.rd_data), 32'(modelQ[0]));
            void'(modelQ.pop_front());
        end else begin
            checkOutput("empty_data", 32'(bus.rd_data), 32'h0);
        end
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_empty"}, 32'(bus.empty), 32'(modelQ.size() == 0));
        checkOutput({tag, "_full"}, 32'(bus.full), 32'(modelQ.size() == DEPTH));
        checkOutput({tag, "_ovr"}, 32'(overrunCnt), 32'(expOverrun));
        checkOutput({tag, "_ferr"}, 32'(frameErrCnt), 32'(expFrameErr));
        checkOutput({tag, "_perr"}, 32'(parityErrCnt), 32'(expParity));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] b;
        bus.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_empty", 32'(bus.empty), 32'h1);
        checkOutput("rst_full", 32'(bus.full), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_data", 32'(bus.rd_data), 32'h0);
        checkOutput("rst_errs", 32'({frame_err, overrun, parity_err}), 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] single frame");
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        modelPush(8'hA5);
        checkOutput("stop_empty_before", 32'(snapBefore), 32'h1);
        checkOutput("stop_empty_after", 32'(snapAfter), 32'h0);
        checkOutput("stop_data_after", 32'(snapData), 32'hA5);
        popCheck();
        checkStatus("single");

        $display("[TB] fill and overrun");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            modelPush(8'(i));
            checkStatus("fill");
        end
        for (int i = 0; i < 5; i++) popCheck();

        $display("[TB] push and pop while full");
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            modelPush(8'(i));
        end
        applyStimulus(8'h05, 1'b1, 1'b0, 1'b1, 1'b0);
        void'(modelQ.pop_front());
        modelQ.push_back(8'h05);
        checkStatus("pushpop");
        for (int i = 0; i < 4; i++) popCheck();
        checkStatus("drained");

        $display("[TB] framing error and break");
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        expFrameErr++;
        repeat (3 * CLKS) @(negedge clk);
        checkOutput("break_busy", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("break_idle", 32'(busy), 32'h0);
        checkStatus("ferr");
        applyStimulus(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
        modelPush(8'h7E);
        checkStatus("after_ferr");
        popCheck();

        $display("[TB] glitch");
        busyCycles = 0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CLKS) @(negedge clk);
        checkOutput("glitch_busy_len", 32'(busyCycles), 32'(CLKS / 2));
        checkOutput("glitch_idle", 32'(busy), 32'h0);
        checkStatus("glitch");

        $display("[TB] mid-frame reset");
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("rstmid_busy", 32'(busy), 32'h0);
        checkStatus("rstmid");
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        modelPush(8'h55);
        checkStatus("rstmid_next");
        popCheck();

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity");
        applyStimulus(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
        modelPush(8'h03);
        checkStatus("par_ok");
        popCheck();
        applyStimulus(8'h03, 1'b1, 1'b1, 1'b0, 1'b0);
        expParity++;
        checkStatus("par_bad");
`endif

        $display("[TB] random traffic");
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom);
            applyStimulus(b, 1'b1, 1'b0, 1'b0, 1'b0);
            modelPush(b);
            checkStatus("rand");
            for (int p = 0; p < int'($urandom_range(0, 2)); p++) popCheck();
        end
        while (modelQ.size() != 0) popCheck();
        popCheck();
        checkStatus("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
